// File: rtl/sid_env_ctrl.sv
// sid_env_ctrl: register front-end and sequencer for the three SID envelope generators.
//   Decodes CPU writes to the per-voice CONTROL/AD/SR registers into shadow storage,
//   commits the shadows to the envelope inputs on the envelope tick, generates that
//   tick (clk_en) and serves ENV3 readback.
// Ports:
//   clk, n_reset          system clock, asynchronous active-low reset
//   bus_addr/wdata/we/re  CPU register bus request (1-cycle strobes)
//   bus_rdata/bus_ack     registered response, valid the cycle after the strobe
//   env3_vol              voice 2 envelope level, returned on reads of 0x1C
//   clk_en                envelope tick, high 1 cycle in CLK_DIV
//   gate, atk, dcy, stn, rls  committed envelope controls, voice n in bit n / [4n+3:4n]
// Configuration macro: SID_ENV_CTRL_READBACK_EN makes CONTROL/AD/SR readable (shadow value).
module sid_env_ctrl #(
   parameter int unsigned CLK_DIV = 16
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [4:0]  bus_addr,
   input  logic [7:0]  bus_wdata,
   input  logic        bus_we,
   input  logic        bus_re,
   output logic [7:0]  bus_rdata,
   output logic        bus_ack,
   input  logic [7:0]  env3_vol,
   output logic        clk_en,
   output logic [2:0]  gate,
   output logic [11:0] atk,
   output logic [11:0] dcy,
   output logic [11:0] stn,
   output logic [11:0] rls
);

   localparam int unsigned CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned NVOICE   = 3;
   localparam logic [4:0]  ENV3_ADR = 5'h1C;

   logic [CNT_W-1:0] cnt;
   logic [2:0]       sh_gate;
   logic [2:0]       pend_rise;
   logic [11:0]      sh_atk, sh_dcy, sh_stn, sh_rls;
   logic [7:0]       rd_val_c;

   // Tick divider: clk_en is high in the cycle after the count reaches its last value.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cnt    <= '0;
         clk_en <= 1'b0;
      end else begin
         clk_en <= (cnt == CNT_W'(CLK_DIV - 1));
         if (cnt == CNT_W'(CLK_DIV - 1)) cnt <= '0;
         else                            cnt <= cnt + CNT_W'(1);
      end
   end

   // Shadow registers and pending gate rises. A rise written on the commit edge
   // must survive that commit, so the set takes priority over the clear.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         sh_gate   <= '0;
         pend_rise <= '0;
         sh_atk    <= '0;
         sh_dcy    <= '0;
         sh_stn    <= '0;
         sh_rls    <= '0;
      end else begin
         for (int n = 0; n < int'(NVOICE); n++) begin
            if (bus_we && bus_addr == 5'(7 * n + 4)) sh_gate[n] <= bus_wdata[0];
            if (bus_we && bus_addr == 5'(7 * n + 5)) begin
               sh_atk[4*n +: 4] <= bus_wdata[7:4];
               sh_dcy[4*n +: 4] <= bus_wdata[3:0];
            end
            if (bus_we && bus_addr == 5'(7 * n + 6)) begin
               sh_stn[4*n +: 4] <= bus_wdata[7:4];
               sh_rls[4*n +: 4] <= bus_wdata[3:0];
            end
            if (bus_we && bus_addr == 5'(7 * n + 4) && bus_wdata[0] && !sh_gate[n])
               pend_rise[n] <= 1'b1;
            else if (clk_en)
               pend_rise[n] <= 1'b0;
         end
      end
   end

   // Commit: outputs load the shadows on the tick; a pending rise forces one tick of gate.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         gate <= '0;
         atk  <= '0;
         dcy  <= '0;
         stn  <= '0;
         rls  <= '0;
      end else if (clk_en) begin
         gate <= sh_gate | pend_rise;
         atk  <= sh_atk;
         dcy  <= sh_dcy;
         stn  <= sh_stn;
         rls  <= sh_rls;
      end
   end

   // Read data mux; unmapped and write-only addresses read 0x00.
   always_comb begin
      rd_val_c = 8'h00;
      if (bus_addr == ENV3_ADR) rd_val_c = env3_vol;
`ifdef SID_ENV_CTRL_READBACK_EN
      for (int n = 0; n < int'(NVOICE); n++) begin
         if (bus_addr == 5'(7 * n + 4)) rd_val_c = {7'b0, sh_gate[n]};
         if (bus_addr == 5'(7 * n + 5)) rd_val_c = {sh_atk[4*n +: 4], sh_dcy[4*n +: 4]};
         if (bus_addr == 5'(7 * n + 6)) rd_val_c = {sh_stn[4*n +: 4], sh_rls[4*n +: 4]};
      end
`endif
   end

   // Bus response: one ack per strobe; a simultaneous write drops the read.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         bus_ack   <= 1'b0;
         bus_rdata <= 8'h00;
      end else begin
         bus_ack   <= bus_we | bus_re;
         bus_rdata <= (bus_re && !bus_we) ? rd_val_c : 8'h00;
      end
   end

endmodule
